aes_out_serializer: RTL and testbench

Downstream stage for the pipelined `aes_128` core. It tracks which core inputs carried real blocks by passing a launch flag through a delay line matched to the core's fixed latency. It captures each valid 128-bit ciphertext into a small FIFO. It then streams the ciphertext out as 32-bit words over a valid/ready interface, so a narrow bus or DMA can drain results without stalling the free-running core.

---
 rtl/aes_ser_pkg.sv | 20 ++
 rtl/aes_ser_fifo.sv | 58 +++++
 rtl/aes_out_serializer.sv | 134 +++++++++++++
 tb/tb_aes_out_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ser_pkg.sv
// rtl/aes_ser_pkg.sv - shared widths, latency, word-index and state types for the AES output serializer
package aes_ser_pkg;

    localparam int WORD_W         = 32;
    localparam int BLK_W          = 128;
    localparam int WORDS_PER_BLK  = 4;
    localparam int AES128_LATENCY = 21;

    typedef logic [1:0] widx_t;

    typedef enum logic {
        ST_EMPTY     = 1'b0,
        ST_STREAMING = 1'b1
    } ser_state_e;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_ser_fifo.sv
// rtl/aes_ser_fifo.sv - synchronous block FIFO with count/full/empty and same-cycle push/pop
// A push while full is still accepted when a pop happens in the same cycle.
module aes_ser_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - launch delay line, block capture FIFO and 32-bit word streamer for aes_128
// Optional AES_SER_BYTESWAP_EN byte-reverses every output word for little-endian sinks.
module aes_out_serializer
    import aes_ser_pkg::*;
#(
    parameter int LATENCY = AES128_LATENCY,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   launch,
    input  logic [BLK_W-1:0]       ct,
    output logic [WORD_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LATENCY-1:0] dly;
    logic               tap;
    logic               xfer;
    logic               pop;
    logic               wr_acc;
    logic               overflow_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [BLK_W-1:0]   head;
    logic [WORD_W-1:0]  word_sel;
    widx_t              widx;
    ser_state_e         state;
    ser_state_e         state_nxt;

    // Launch flag travels alongside the core pipeline; the tap marks a real ciphertext on ct.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly <= '0;
        end else begin
            dly <= (dly << 1) | LATENCY'(launch);
        end
    end

    assign tap    = dly[LATENCY-1];
    assign xfer   = m_valid && m_ready;
    assign pop    = xfer && (widx == widx_t'(WORDS_PER_BLK - 1));
    assign wr_acc = tap && (!fifo_full || pop);

    aes_ser_fifo #(
        .DEPTH (DEPTH),
        .W     (BLK_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tap),
        .pop   (pop),
        .wdata (ct),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (tap && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            widx <= '0;
        end else if (xfer) begin
            widx <= widx + widx_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (wr_acc) begin
                    state_nxt = ST_STREAMING;
                end
            end
            ST_STREAMING: begin
                if (pop && !wr_acc && (fifo_count == CW'(1))) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        word_sel = '0;
        case (widx)
            2'd0:    word_sel = head[127:96];
            2'd1:    word_sel = head[95:64];
            2'd2:    word_sel = head[63:32];
            default: word_sel = head[31:0];
        endcase
    end

    always_comb begin
        m_valid = (state == ST_STREAMING) && !fifo_empty;
        m_last  = m_valid && (widx == widx_t'(WORDS_PER_BLK - 1));
        m_data  = '0;
        if (m_valid) begin
`ifdef AES_SER_BYTESWAP_EN
            m_data = bswap32(word_sel);
`else
            m_data = word_sel;
`endif
        end
    end

    assign level    = fifo_count;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// tb/tb_aes_out_serializer.sv - self-checking bench for aes_out_serializer
module tb_aes_out_serializer;

    localparam int L  = 21;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          launch;
    logic [127:0]  ct;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [LW-1:0] level;
    logic          overflow;

    always #5 clk = ~clk;

    aes_out_serializer #(
        .LATENCY (L),
        .DEPTH   (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .launch   (launch),
        .ct       (ct),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .level    (level),
        .overflow (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_on = 1'b0;

    logic [127:0] q[$];
    int           widx_m = 0;
    bit           ovf_m  = 1'b0;
    logic [127:0] sched_ct [64];
    bit           sched_v  [64];

    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_last;
    logic [LW-1:0] s_level;
    logic          s_ovf;

    typedef struct {
        bit          rdy;
        bit          v;
        logic [31:0] d;
        bit          last;
    } vec_t;

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        logic [127:0] t;
        logic [31:0]  w;
        t = b >> (32 * (3 - i));
        w = t[31:0];
`ifdef AES_SER_BYTESWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the queue model, then advance the model.
    task automatic tick(input bit l, input bit r, input logic [127:0] blk, input bit rs);
        int          s;
        bit          ev;
        bit          el;
        logic [31:0] ed;
        s = cyc % 64;
        rst     = rs;
        launch  = l;
        m_ready = r;
        ct = sched_v[s] ? sched_ct[s] : {$urandom, $urandom, $urandom, $urandom};
        #3;
        s_valid = m_valid;
        s_data  = m_data;
        s_last  = m_last;
        s_level = level;
        s_ovf   = overflow;
        ev = (q.size() > 0);
        ed = ev ? word_of(q[0], widx_m) : 32'h0;
        el = ev && (widx_m == 3);
        if (model_on) begin
            checks++;
            if (s_valid !== ev || s_data !== ed || s_last !== el ||
                s_level !== LW'(q.size()) || s_ovf !== ovf_m) begin
                errors++;
                $display("FAIL model cyc=%0d got v=%b d=%h l=%b lvl=%0d ovf=%b required v=%b d=%h l=%b lvl=%0d ovf=%b",
                         cyc, s_valid, s_data, s_last, s_level, s_ovf, ev, ed, el, q.size(), ovf_m);
            end
        end
        if (rs) begin
            q.delete();
            widx_m = 0;
            ovf_m  = 1'b0;
            for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
        end else begin
            if (ev && r) begin
                if (widx_m == 3) void'(q.pop_front());
                widx_m = (widx_m + 1) % 4;
            end
            if (sched_v[s]) begin
                if (q.size() < D) q.push_back(sched_ct[s]);
                else ovf_m = 1'b1;
            end
            sched_v[s] = 1'b0;
            if (l) begin
                sched_v[(cyc + L) % 64]  = 1'b1;
                sched_ct[(cyc + L) % 64] = blk;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] fips;
    logic [31:0]  fw [4];
    vec_t         tbl [11];
    int           n;

    initial begin
        fips = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_SER_BYTESWAP_EN
        fw[0] = 32'hd8e0c469; fw[1] = 32'h30047b6a; fw[2] = 32'h80b7cdd8; fw[3] = 32'h5ac5b470;
`else
        fw[0] = 32'h69c4e0d8; fw[1] = 32'h6a7b0430; fw[2] = 32'hd8cdb780; fw[3] = 32'h70b4c55a;
`endif
        tbl[0]  = '{1, 1, fw[0], 0};
        tbl[1]  = '{0, 1, fw[1], 0};
        tbl[2]  = '{0, 1, fw[1], 0};
        tbl[3]  = '{1, 1, fw[1], 0};
        tbl[4]  = '{0, 1, fw[2], 0};
        tbl[5]  = '{0, 1, fw[2], 0};
        tbl[6]  = '{1, 1, fw[2], 0};
        tbl[7]  = '{0, 1, fw[3], 1};
        tbl[8]  = '{0, 1, fw[3], 1};
        tbl[9]  = '{1, 1, fw[3], 1};
        tbl[10] = '{1, 0, 32'h0, 0};
        for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;

        rst = 1'b1; launch = 1'b0; m_ready = 1'b0; ct = '0;
        @(posedge clk);
        #1;
        tick(0, 0, '0, 1);
        tick(0, 0, '0, 1);
        model_on = 1'b1;

        tick(0, 0, '0, 0);
        chk("reset_valid", s_valid, 0);
        chk("reset_last", s_last, 0);
        chk("reset_data", s_data, 0);
        chk("reset_level", s_level, 0);
        chk("reset_overflow", s_ovf, 0);

        // FIPS-197 ciphertext with the sink always ready
        tick(1, 1, fips, 0);
        for (int k = 1; k <= 21; k++) tick(0, 1, '0, 0);
        chk("fips_valid_before_22", s_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, '0, 0);
            chk("fips_valid", s_valid, 1);
            chk("fips_word", s_data, fw[k]);
            chk("fips_last", s_last, (k == 3));
        end
        tick(0, 1, '0, 0);
        chk("fips_valid_after", s_valid, 0);

        // Same vector with a stalling sink, table-driven
        tick(1, 1, fips, 0);
        for (int k = 1; k <= 21; k++) tick(0, 1, '0, 0);
        for (int k = 0; k < 11; k++) begin
            tick(0, tbl[k].rdy, '0, 0);
            chk("bp_valid", s_valid, tbl[k].v);
            chk("bp_data", s_data, tbl[k].d);
            chk("bp_last", s_last, tbl[k].last);
        end

        // Overflow: five launches into a stalled sink
        for (int i = 0; i <= 37; i++) tick((i % 4 == 0) && (i <= 16), 0, rnd_blk(), 0);
        tick(0, 0, '0, 0);
        chk("ovf_level", s_level, 4);
        chk("ovf_flag", s_ovf, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, '0, 0);
            if (s_valid === 1'b1) n++;
        end
        chk("ovf_word_count", n, 16);
        chk("ovf_sticky", s_ovf, 1);
        tick(0, 0, '0, 1);

        // Full FIFO: capture coincides with last-word pop
        for (int i = 0; i <= 35; i++)
            tick((i == 0) || (i == 4) || (i == 8) || (i == 12) || (i == 14), (i >= 32), rnd_blk(), 0);
        tick(0, 0, '0, 0);
        chk("fullpop_level", s_level, 4);
        chk("fullpop_overflow", s_ovf, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, '0, 0);
            if (s_valid === 1'b1) n++;
        end
        chk("fullpop_word_count", n, 16);

        // Reset during word 2 with a second block in flight
        for (int i = 0; i <= 23; i++) tick((i == 0) || (i == 4), 1, rnd_blk(), 0);
        tick(1, 1, rnd_blk(), 1);
        chk("rst_mid_valid_before", s_valid, 1);
        tick(0, 1, '0, 0);
        chk("rst_mid_valid", s_valid, 0);
        chk("rst_mid_level", s_level, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, '0, 0);
            if (s_valid === 1'b1) n++;
        end
        chk("rst_mid_no_words", n, 0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, rnd_blk(), $urandom_range(0, 499) == 0);
        for (int i = 0; i < 60; i++) tick(0, 1, '0, 0);
        chk("final_drained", s_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
